// File: rtl/nxs_pkg.sv
// Shared widths, scheduler state type and nonce partitioning helper for the
// Nexus work scheduler.
package nxs_pkg;

    localparam int WORK_W     = 1728;
    localparam int NONCE_W    = 64;
    localparam int MIDSTATE_W = 1088;
    localparam int HDR_W      = 640;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } sched_state_t;

    // Top log2(n) bits of the nonce select the core's disjoint slice.
    function automatic logic [NONCE_W-1:0] nonce_base(input int idx, input int n);
        if (n <= 1) begin
            return '0;
        end
        return NONCE_W'(idx) << (NONCE_W - $clog2(n));
    endfunction

endpackage

// File: rtl/nxs_result_fifo.sv
// Synchronous result FIFO with flush; head is driven from registered
// storage only.
module nxs_result_fifo
    import nxs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = NONCE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign dout  = mem_q[rd_q];

    always_comb begin
        do_pop  = pop && valid;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nxs_work_scheduler.sv
// Work broadcast, core reload sequencing and round-robin hit collection.
// Optional RUN idle timeout enabled by defining NXS_WORK_TIMEOUT_EN.
module nxs_work_scheduler
    import nxs_pkg::*;
#(
    parameter int          NUM_CORES      = 4,
    parameter int          RELOAD_CYCLES  = 4,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         work_valid,
    input  logic [WORK_W-1:0]            work_data,
    output logic [WORK_W-1:0]            core_work,
    output logic [NONCE_W*NUM_CORES-1:0] core_nonce_base,
    output logic [NUM_CORES-1:0]         core_nrst,
    input  logic [NUM_CORES-1:0]         core_found,
    input  logic [NONCE_W*NUM_CORES-1:0] core_nonce,
    output logic                         out_valid,
    output logic [NONCE_W-1:0]           out_nonce,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [15:0]                  drop_count
);

    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    sched_state_t                 state_q, state_d;
    logic [7:0]                   rcnt_q, rcnt_d;
    logic [WORK_W-1:0]            work_q, work_d;
    logic [NONCE_W*NUM_CORES-1:0] base_q, base_d;
    logic [NUM_CORES-1:0]         nrst_q, nrst_d;
    logic                         busy_q, busy_d;
    logic [NUM_CORES-1:0]         pend_q, pend_d;
    logic [NONCE_W-1:0]           pnon_q [NUM_CORES];
    logic [NONCE_W-1:0]           pnon_d [NUM_CORES];
    logic [CW-1:0]                last_q, last_d;
    logic [15:0]                  drop_q, drop_d;
    logic                         gnt_vld;
    logic [CW-1:0]                gnt_idx;
    logic [CW-1:0]                cand;
    logic                         fifo_full;
    logic                         tmo_hit;

`ifdef NXS_WORK_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (state_q == ST_RUN && !work_valid) begin
            tmo_hit = (tmo_q == TIMEOUT_CYCLES - 32'd1);
            tmo_d   = tmo_hit ? '0 : tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        work_d  = work_q;
        base_d  = base_q;
        nrst_d  = nrst_q;
        busy_d  = busy_q;
        if (work_valid) begin
            state_d = ST_LOAD;
            rcnt_d  = 8'(RELOAD_CYCLES - 1);
            work_d  = {work_data[WORK_W-1 -: MIDSTATE_W], work_data[HDR_W-1:0]};
            nrst_d  = '0;
            busy_d  = 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                base_d[i*NONCE_W +: NONCE_W] = nonce_base(i, NUM_CORES);
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    nrst_d = '0;
                    busy_d = 1'b0;
                end
                ST_LOAD: begin
                    if (rcnt_q == 8'd0) begin
                        state_d = ST_RUN;
                        nrst_d  = '1;
                        busy_d  = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (tmo_hit) begin
                        state_d = ST_IDLE;
                        nrst_d  = '0;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Search starts one past the last winner so every core gets a turn.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        cand    = last_q;
        if (state_q == ST_RUN && !work_valid && !tmo_hit && !fifo_full) begin
            for (int k = 1; k <= NUM_CORES; k++) begin
                cand = CW'((int'(last_q) + k) % NUM_CORES);
                if (!gnt_vld && pend_q[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        pnon_d = pnon_q;
        drop_d = drop_q;
        last_d = gnt_vld ? gnt_idx : last_q;
        if (work_valid || tmo_hit) begin
            pend_d = '0;
        end else if (state_q == ST_RUN) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_found[i]) begin
                    if (pend_q[i] && !(gnt_vld && gnt_idx == CW'(i))
                        && drop_d != 16'hFFFF) begin
                        drop_d = drop_d + 16'd1;
                    end
                    pend_d[i] = 1'b1;
                    pnon_d[i] = core_nonce[i*NONCE_W +: NONCE_W];
                end else if (gnt_vld && gnt_idx == CW'(i)) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            work_q  <= '0;
            base_q  <= '0;
            nrst_q  <= '0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                pnon_q[i] <= '0;
            end
            last_q  <= CW'(NUM_CORES - 1);
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            work_q  <= work_d;
            base_q  <= base_d;
            nrst_q  <= nrst_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            pnon_q  <= pnon_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    nxs_result_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (NONCE_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(work_valid),
        .push (gnt_vld),
        .din  (pnon_q[gnt_idx]),
        .pop  (out_ready),
        .valid(out_valid),
        .dout (out_nonce),
        .full (fifo_full)
    );

    assign core_work       = work_q;
    assign core_nonce_base = base_q;
    assign core_nrst       = nrst_q;
    assign busy            = busy_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_nxs_work_scheduler.sv
// Directed self-checking bench for nxs_work_scheduler (4 cores, depth 4).
module tb_nxs_work_scheduler;
    import nxs_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             work_valid = 1'b0;
    logic [WORK_W-1:0] work_data = '0;
    logic [WORK_W-1:0] core_work;
    logic [255:0]     core_nonce_base;
    logic [3:0]       core_nrst;
    logic [3:0]       core_found = '0;
    logic [255:0]     core_nonce = '0;
    logic             out_valid;
    logic [63:0]      out_nonce;
    logic             out_ready = 1'b0;
    logic             busy;
    logic [15:0]      drop_count;

    int total = 0;
    int bad = 0;

    nxs_work_scheduler #(
        .NUM_CORES     (4),
        .RELOAD_CYCLES (4),
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .work_valid     (work_valid),
        .work_data      (work_data),
        .core_work      (core_work),
        .core_nonce_base(core_nonce_base),
        .core_nrst      (core_nrst),
        .core_found     (core_found),
        .core_nonce     (core_nonce),
        .out_valid      (out_valid),
        .out_nonce      (out_nonce),
        .out_ready      (out_ready),
        .busy           (busy),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++;
        if (core_nrst !== 4'b0000) begin
            bad++; $display("FAIL rst_nrst got=%b exp=0000", core_nrst);
        end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_flags got=%b%b exp=00", out_valid, busy);
        end
        total++;
        if (drop_count !== 16'd0 || core_work !== '0) begin
            bad++; $display("FAIL rst_regs drop=%h exp=0", drop_count);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        logic [63:0] exp_base [4];
        logic [WORK_W-1:0] wd;
        exp_base = '{64'h0, 64'h4000_0000_0000_0000,
                     64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000};
        wd = {216{8'hA5}};
        work_data  = wd;
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        work_data  = '0;
        total++;
        if (core_work !== wd) begin
            bad++; $display("FAIL load_work got=%h exp=a5..", core_work[31:0]);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (core_nonce_base[64*i +: 64] !== exp_base[i]) begin
                bad++;
                $display("FAIL load_base%0d got=%h exp=%h",
                         i, core_nonce_base[64*i +: 64], exp_base[i]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            total++;
            if (core_nrst !== 4'b0000 || busy !== 1'b0) begin
                bad++; $display("FAIL load_hold%0d got=%b exp=0000", c, core_nrst);
            end
            tick();
        end
        total++;
        if (core_nrst !== 4'b1111 || busy !== 1'b1) begin
            bad++; $display("FAIL load_run got=%b busy=%b exp=1111 1", core_nrst, busy);
        end
    endtask

    task automatic test_burst();
        out_ready  = 1'b1;
        core_found = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            core_nonce[64*i +: 64] = 64'h10 + 64'(i);
        end
        tick();
        core_found = '0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL burst_lat1 got=%b exp=0", out_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_nonce !== 64'h10 + 64'(i)) begin
                bad++;
                $display("FAIL burst_seq%0d got=%b/%h exp=1/%h",
                         i, out_valid, out_nonce, 64'h10 + 64'(i));
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || drop_count !== 16'd0) begin
            bad++; $display("FAIL burst_end got=%b drop=%0d exp=0 0", out_valid, drop_count);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] exp_seq [5];
        exp_seq = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd7};
        out_ready = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            core_found = 4'b0100;
            core_nonce[128 +: 64] = 64'(j);
            tick();
        end
        core_found = '0;
        tick();
        tick();
        total++;
        if (drop_count !== 16'd2) begin
            bad++; $display("FAIL ovf_drop got=%0d exp=2", drop_count);
        end
        total++;
        if (out_valid !== 1'b1 || out_nonce !== 64'd1) begin
            bad++; $display("FAIL ovf_hold got=%b/%h exp=1/1", out_valid, out_nonce);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_nonce !== exp_seq[i]) begin
                bad++;
                $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h",
                         i, out_valid, out_nonce, exp_seq[i]);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL ovf_empty got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready  = 1'b0;
        core_found = 4'b0111;
        core_nonce[0 +: 64]   = 64'h21;
        core_nonce[64 +: 64]  = 64'h22;
        core_nonce[128 +: 64] = 64'h23;
        tick();
        core_found = '0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL flush_pre got=%b exp=1", out_valid);
        end
        work_data  = {216{8'h3C}};
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_empty got=%b exp=0", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            core_found = 4'b1111;
            for (int k = 0; k < 4; k++) core_nonce[64*k +: 64] = 64'h99;
            total++;
            if (out_valid !== 1'b0 || core_nrst !== 4'b0000) begin
                bad++; $display("FAIL flush_load%0d got=%b/%b exp=0/0000", i, out_valid, core_nrst);
            end
            tick();
        end
        core_found = '0;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || drop_count !== 16'd2) begin
            bad++;
            $display("FAIL flush_ign got=%b busy=%b drop=%0d exp=0 1 2", out_valid, busy, drop_count);
        end
        out_ready  = 1'b1;
        core_found = 4'b0010;
        core_nonce[64 +: 64] = 64'h55;
        tick();
        core_found = '0;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_nonce !== 64'h55) begin
            bad++; $display("FAIL flush_new got=%b/%h exp=1/55", out_valid, out_nonce);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready  = 1'b0;
        core_found = 4'b1000;
        core_nonce[192 +: 64] = 64'h77;
        tick();
        core_found = '0;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_nonce !== 64'h77) begin
            bad++; $display("FAIL mid_pre got=%b/%h exp=1/77", out_valid, out_nonce);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (core_nrst !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0
            || drop_count !== 16'd0) begin
            bad++;
            $display("FAIL mid_rst got nrst=%b v=%b busy=%b drop=%0d exp=0000 0 0 0",
                     core_nrst, out_valid, busy, drop_count);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

`ifdef NXS_WORK_TIMEOUT_EN
    task automatic test_timeout();
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 99; i++) tick();
        total++;
        if (busy !== 1'b1 || core_nrst !== 4'b1111) begin
            bad++; $display("FAIL tmo_before got=%b/%b exp=1/1111", busy, core_nrst);
        end
        tick();
        total++;
        if (busy !== 1'b0 || core_nrst !== 4'b0000) begin
            bad++; $display("FAIL tmo_after got=%b/%b exp=0/0000", busy, core_nrst);
        end
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (busy !== 1'b1 || core_nrst !== 4'b1111) begin
            bad++; $display("FAIL tmo_restart got=%b/%b exp=1/1111", busy, core_nrst);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_burst();
        test_overflow();
        test_flush();
        test_reset_mid();
`ifdef NXS_WORK_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
